button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Front end of the push-pin calculator: conditions the four raw push buttons and the 8-bit switch word
//  before they reach the CPU. Synchronises, debounces and edge-detects each button, then issues one-cycle
//  command pulses (Sample, Btns[2:0]) at most one per cycle. Latches the switch word as Din alongside Sample.
//  Sits between board I/O (KEY/SW) and the CPU's Sample/Btns/Din inputs.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required to accept a level change (20 ms @ 50 MHz)
//  TURBO_CYCLES     1          stable cycles required when Turbo=1 (simulation / fast bring-up)
//  SYNC_STAGES      2          flip-flop synchroniser depth on PbRaw and DinRaw (>=2)
// PORTS
//  Clk      in   1  system clock, 50 MHz
//  Reset    in   1  asynchronous, active-high reset
//  Turbo    in   1  1 = use TURBO_CYCLES, 0 = use DEBOUNCE_CYCLES; sampled every cycle
//  PbRaw    in   4  raw buttons, active-high: [3]=Push/Sample, [2]=Pop, [1]=Add, [0]=Mult
//  DinRaw   in   8  raw switch word (signed operand)
//  Sample   out  1  one-cycle push command to CPU
//  Btns     out  3  one-cycle commands to CPU: [2]=Pop, [1]=Add, [0]=Mult; one-hot or zero
//  Din      out  8  operand; loaded from synchronised DinRaw on the edge that raises Sample, held otherwise
//  Held     out  4  debounced button levels (for LEDs/debug)
// BEHAVIOUR
//  Reset: all sync FFs, counters, stable levels, pending bits, Sample, Btns, Din, Held = 0. Reset asserted
//   mid-debounce or with pending commands discards them; no pulse is emitted for a button already held at
//   release of reset until it is released and pressed again.
//  Sync: PbRaw[i] and DinRaw pass through SYNC_STAGES FFs; s[i] = last stage.
//  Debounce per button: stable[i], cnt[i] of width $clog2(DEBOUNCE_CYCLES+1). If s[i]==stable[i]: cnt<=0.
//   Else cnt<=cnt+1; when cnt+1 == limit (limit = Turbo ? TURBO_CYCLES : DEBOUNCE_CYCLES): stable[i]<=s[i],
//   cnt<=0. Any bounce back to stable value restarts the count. Turbo toggling mid-count applies new limit
//   immediately; if cnt already >= new limit, accept on the next differing cycle. Counter never wraps.
//  Held = stable. A 0->1 transition of stable[i] sets pending[i]; 1->0 does nothing.
//  Issue: each cycle, highest-priority pending bit (3 > 2 > 1 > 0) is issued and cleared; its output is
//   registered high for exactly one cycle. Others stay pending and issue on following cycles, so
//   Sample|Btns is never more than one-hot. A new rising edge on a bit already pending is merged (no double).
//  Latency (no contention, first edge sampling raw high = edge 1): pulse high after edge
//   SYNC_STAGES+limit+1, i.e. edge 4 with Turbo=1, defaults. Raw pulse must be seen by >=1 clock edge and
//   stay stable limit cycles after synchronisation.
//  Din: captured from synchronised DinRaw on the same edge Sample goes high; stable until next Sample.
// STRUCTURE
//  Package calc_pkg: localparams BTN_PUSH=3, BTN_POP=2, BTN_ADD=1, BTN_MULT=0; NUM_BTNS=4; DATA_W=8.
//  Sub-module debounce_cell (one per button, generate loop): sync chain + counter + stable level, outputs
//   level and rise strobe. Top holds pending bits, priority issue logic and Din register.
// TESTING
//  Reset held 2 cycles, PbRaw=4'b1000 asserted during reset then released -> no Sample until re-pressed.
//  Turbo=1, DinRaw=8'd5, PbRaw[3] high 25 ns -> Sample high exactly 1 cycle at edge 4, Din=5 thereafter.
//  Turbo=1, DinRaw=8'hFD (-3) push then PbRaw[0] pulse -> Sample then Btns=3'b001, Din=-3 held.
//  Turbo=0, DEBOUNCE_CYCLES=8: PbRaw[1] bounces 1,0,1 every 3 cycles then steady 12 -> one Btns[1] pulse
//   only, 8 cycles after last bounce + sync.
//  PbRaw=4'b1111 in one cycle, Turbo=1 -> Sample, Btns=100, 010, 001 on four consecutive cycles.
//  Reset asserted one cycle after pending set for Pop -> no Btns pulse; Held=0; Din=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the push-pin calculator front end: button indices and data width.
package calc_pkg;

    localparam int BTN_PUSH = 3;
    localparam int BTN_POP  = 2;
    localparam int BTN_ADD  = 1;
    localparam int BTN_MULT = 0;

    localparam int NUM_BTNS = 4;
    localparam int DATA_W   = 8;

endpackage

// File: rtl/debounce_cell.sv
// One button: synchroniser, stability counter and debounced level with a one-cycle rise strobe.
// Rise is registered with the stable level; no backpressure (strobe is consumed by the parent).
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TURBO_CYCLES    = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic turbo,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic [CNT_W-1:0]       cnt;
    logic                   stable;
    logic                   armed;
    logic                   s;
    logic                   s_ok;
    logic [31:0]            limit;
    logic [31:0]            cnt_next;

    assign s        = sync_q[SYNC_STAGES-1];
    assign s_ok     = fill_q[SYNC_STAGES-1];
    assign limit    = turbo ? 32'(TURBO_CYCLES) : 32'(DEBOUNCE_CYCLES);
    assign cnt_next = 32'(cnt) + 32'd1;
    assign level    = stable;

    // fill_q marks when the sync chain holds real samples; a button only becomes
    // armed once it has been seen released, so a press held through reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            armed  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            rise   <= 1'b0;
            if (s_ok && !s) begin
                armed <= 1'b1;
            end
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt_next >= limit) begin
                // >= rather than == so a limit lowered mid-count accepts immediately
                stable <= s;
                cnt    <= '0;
                rise   <= s & armed;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions KEY/SW for the calculator CPU: debounced buttons become one-hot single-cycle commands.
// Pulse one cycle after the debounced rise; simultaneous presses queue as pending and issue by priority.
module button_conditioner
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TURBO_CYCLES    = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Turbo,
    input  logic [NUM_BTNS-1:0] PbRaw,
    input  logic [DATA_W-1:0]   DinRaw,
    output logic                Sample,
    output logic [2:0]          Btns,
    output logic [DATA_W-1:0]   Din,
    output logic [NUM_BTNS-1:0] Held
);

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] pending;
    logic [NUM_BTNS-1:0] req;
    logic [NUM_BTNS-1:0] grant;
    logic [DATA_W-1:0]   din_sync [SYNC_STAGES];

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .TURBO_CYCLES   (TURBO_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_cell (
            .clk  (Clk),
            .rst  (Reset),
            .turbo(Turbo),
            .raw  (PbRaw[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    assign Held = level;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                din_sync[k] <= '0;
            end
        end else begin
            din_sync[0] <= DinRaw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                din_sync[k] <= din_sync[k-1];
            end
        end
    end

    // Fresh rise strobes join the pending set directly, so an uncontended press
    // issues on the cycle after it is debounced; a repeat rise merges into its bit.
    always_comb begin
        req   = pending | rise;
        grant = '0;
        if (req[BTN_PUSH]) begin
            grant[BTN_PUSH] = 1'b1;
        end else if (req[BTN_POP]) begin
            grant[BTN_POP] = 1'b1;
        end else if (req[BTN_ADD]) begin
            grant[BTN_ADD] = 1'b1;
        end else if (req[BTN_MULT]) begin
            grant[BTN_MULT] = 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pending <= '0;
            Sample  <= 1'b0;
            Btns    <= '0;
            Din     <= '0;
        end else begin
            pending <= req & ~grant;
            Sample  <= grant[BTN_PUSH];
            Btns    <= {grant[BTN_POP], grant[BTN_ADD], grant[BTN_MULT]};
            if (grant[BTN_PUSH]) begin
                Din <= din_sync[SYNC_STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses are queued at stimulus time, a monitor checks them.
module tb_button_conditioner;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       Turbo  = 1'b1;
    logic [3:0] PbRaw  = 4'b0000;
    logic [7:0] DinRaw = 8'h00;
    logic       Sample;
    logic [2:0] Btns;
    logic [7:0] Din;
    logic [3:0] Held;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] code;
        logic [7:0] din;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    button_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .TURBO_CYCLES   (1),
        .SYNC_STAGES    (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Turbo (Turbo),
        .PbRaw (PbRaw),
        .DinRaw(DinRaw),
        .Sample(Sample),
        .Btns  (Btns),
        .Din   (Din),
        .Held  (Held)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] code, input logic [7:0] din, input int at);
        sb.push_back('{code: code, din: din, at: at});
    endtask

    task automatic press(input logic [3:0] mask, input int ncyc);
        PbRaw = mask;
        repeat (ncyc) @(negedge Clk);
        PbRaw = 4'b0000;
    endtask

    // cyc equals the number of rising edges seen so far
    always @(posedge Clk) begin
        #1;
        cyc++;
        if (Sample === 1'b1 || Btns !== 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got code %b din %0h expected none (cycle %0d)",
                         {Sample, Btns}, Din, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_code", 32'({Sample, Btns}), 32'(mon_e.code));
                check("pulse_din", 32'(Din), 32'(mon_e.din));
                check("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        int n;

        // Reset with Push already held: no command until it is released and pressed again
        Reset = 1'b1;
        PbRaw = 4'b1000;
        repeat (2) @(negedge Clk);
        check("rst_sample", 32'(Sample), 32'd0);
        check("rst_btns", 32'(Btns), 32'd0);
        check("rst_din", 32'(Din), 32'd0);
        check("rst_held", 32'(Held), 32'd0);
        Reset = 1'b0;
        repeat (8) @(negedge Clk);
        check("held_through_reset_level", 32'(Held), 32'h8);
        PbRaw = 4'b0000;
        repeat (6) @(negedge Clk);
        check("released_level", 32'(Held), 32'h0);

        // Turbo push with DinRaw=5, pulse four edges after the first sampling edge
        DinRaw = 8'd5;
        expect_pulse(4'b1000, 8'd5, cyc + 4);
        press(4'b1000, 2);
        repeat (8) @(negedge Clk);
        check("din_after_push", 32'(Din), 32'd5);

        // Push -3 then Mult; Din stays -3 even when DinRaw moves on
        DinRaw = 8'hFD;
        expect_pulse(4'b1000, 8'hFD, cyc + 4);
        press(4'b1000, 2);
        repeat (6) @(negedge Clk);
        DinRaw = 8'h11;
        expect_pulse(4'b0001, 8'hFD, cyc + 4);
        press(4'b0001, 2);
        repeat (8) @(negedge Clk);
        check("din_held_neg3", 32'(Din), 32'hFD);

        // Full debounce (8 cycles): bounce 1,0 then steady high gives a single Add
        Turbo = 1'b0;
        n = cyc;
        expect_pulse(4'b0010, 8'hFD, n + 17);
        PbRaw = 4'b0010;
        repeat (3) @(negedge Clk);
        PbRaw = 4'b0000;
        repeat (3) @(negedge Clk);
        PbRaw = 4'b0010;
        repeat (12) @(negedge Clk);
        check("add_debounced_level", 32'(Held), 32'h2);
        PbRaw = 4'b0000;
        repeat (20) @(negedge Clk);
        check("add_released_level", 32'(Held), 32'h0);

        // All four together: Sample, Pop, Add, Mult on consecutive cycles
        Turbo  = 1'b1;
        DinRaw = 8'h3C;
        n = cyc;
        expect_pulse(4'b1000, 8'h3C, n + 4);
        expect_pulse(4'b0100, 8'h3C, n + 5);
        expect_pulse(4'b0010, 8'h3C, n + 6);
        expect_pulse(4'b0001, 8'h3C, n + 7);
        press(4'b1111, 2);
        repeat (10) @(negedge Clk);
        check("din_after_burst", 32'(Din), 32'h3C);

        // Reset lands right after Pop is debounced: the command is discarded
        DinRaw = 8'h77;
        press(4'b0100, 2);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_btns", 32'(Btns), 32'd0);
        check("midrst_held", 32'(Held), 32'd0);
        check("midrst_din", 32'(Din), 32'd0);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check("post_rst_held", 32'(Held), 32'd0);
        check("post_rst_din", 32'(Din), 32'd0);
        check("post_rst_sample", 32'(Sample), 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
